// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, instruction-memory read port and
// the show-ahead instruction stream toward the core.
interface inst_fetch_queue_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   modport master (
      input  redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
      output imem_req, imem_addr, inst_valid, inst_data, inst_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
      input  imem_req, imem_addr, inst_valid, inst_data, inst_pc
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: one outstanding memory read at a time feeding a
// show-ahead queue of {pc, instruction}; redirects flush and refetch.
module inst_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic               clk,
   input logic               reset,
   inst_fetch_queue_if.master bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("inst_fetch_queue: DEPTH must be a power of two in 2..16");
   end

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [31:0]   fetch_pc;
   logic [31:0]   req_addr;
   logic [AW:0]   count;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic          full, issue, push, pop;

   assign full = (count == (AW+1)'(DEPTH));
   assign pop  = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;

   always_comb begin
      state_nxt     = state;
      issue         = 1'b0;
      push          = 1'b0;
      bus.imem_req  = 1'b0;
      bus.imem_addr = req_addr;
      unique case (state)
         IDLE: begin
            bus.imem_addr = fetch_pc;
            // No request is offered in a redirect cycle: it would carry the old pc
            // and then be withdrawn, since the FSM stays in IDLE.
            if (!full && !bus.redirect_valid && !reset) begin
               bus.imem_req = 1'b1;
               issue        = 1'b1;
               state_nxt    = REQ;
            end
         end
         REQ: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ack) begin
               push      = !bus.redirect_valid;
               state_nxt = IDLE;
            end else if (bus.redirect_valid) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         state <= state_nxt;
         if (issue) req_addr <= fetch_pc;
         if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (push) begin
               fetch_pc <= fetch_pc + 32'd4;
               wr_ptr   <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            data_mem[i] <= '0;
         end
      end else if (push) begin
         pc_mem[wr_ptr]   <= req_addr;
         data_mem[wr_ptr] <= bus.imem_rdata;
      end
   end

   assign bus.inst_valid = (count != '0);
   assign bus.inst_pc    = pc_mem[rd_ptr];
   assign bus.inst_data  = data_mem[rd_ptr];
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed vector table, corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_inst_fetch_queue;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   inst_fetch_queue_if bus();

   inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int passed = 0;
   int total  = 0;

   // reference model: queue contents, fetch pointer, outstanding request
   logic [31:0] q_pc[$];
   logic [31:0] q_data[$];
   logic [31:0] m_fetch, m_reqpc;
   logic        m_out, m_drop;
   // memory model
   logic        mem_busy;
   int          mem_wait;
   int          mem_lat;
   logic [31:0] mem_addr;
   // last observed outputs
   logic        obs_req, obs_valid;
   logic [31:0] obs_addr, obs_pc;

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        ack;
      logic [31:0] rdata;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_data;
   } vec_t;
   vec_t vt[12];

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {~a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   // Called at posedge+1 with reset high or low; ends at posedge+1 with reset low.
   task automatic do_reset();
      reset = 1'b1;
      bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
      bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
      #1;
      chk1 ("rst_imem_req", bus.imem_req, 1'b0);
      chk1 ("rst_inst_valid", bus.inst_valid, 1'b0);
      chk32("rst_imem_addr", bus.imem_addr, RESET_PC);
      chk32("rst_inst_pc", bus.inst_pc, 32'h0);
      chk32("rst_inst_data", bus.inst_data, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      q_pc.delete(); q_data.delete();
      m_fetch = RESET_PC; m_reqpc = RESET_PC; m_out = 1'b0; m_drop = 1'b0;
      mem_busy = 1'b0; mem_wait = 0; mem_addr = '0;
   endtask

   // One clock cycle with the memory model answering requests.
   task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
      logic        ack, e_req, e_valid, pop;
      logic [31:0] rdata, e_addr;
      int unsigned sz;
      ack   = mem_busy && (mem_wait == 0);
      rdata = ack ? word_of(mem_addr) : $urandom;
      bus.redirect_valid = rv; bus.redirect_pc = rpc;
      bus.imem_ack = ack; bus.imem_rdata = rdata; bus.inst_ready = rdy;
      #1;
      sz      = q_pc.size();
      e_valid = (sz != 0);
      e_req   = m_out || (sz < DEPTH && !rv);
      e_addr  = m_out ? m_reqpc : m_fetch;
      obs_req = bus.imem_req; obs_addr = bus.imem_addr;
      obs_valid = bus.inst_valid; obs_pc = bus.inst_pc;
      chk1("inst_valid", bus.inst_valid, e_valid);
      chk1("imem_req", bus.imem_req, e_req);
      if (e_req) chk32("imem_addr", bus.imem_addr, e_addr);
      if (e_valid) begin
         chk32("inst_pc", bus.inst_pc, q_pc[0]);
         chk32("inst_data", bus.inst_data, q_data[0]);
      end
      if (ack) mem_busy = 1'b0;
      else if (mem_busy) mem_wait--;
      else if (bus.imem_req) begin
         mem_busy = 1'b1; mem_wait = mem_lat; mem_addr = bus.imem_addr;
      end
      pop = e_valid && rdy;
      if (rv) begin
         q_pc.delete(); q_data.delete();
         m_fetch = {rpc[31:2], 2'b00};
         if (m_out) begin
            if (ack) begin m_out = 1'b0; m_drop = 1'b0; end
            else m_drop = 1'b1;
         end
      end else begin
         if (pop) begin void'(q_pc.pop_front()); void'(q_data.pop_front()); end
         if (m_out) begin
            if (ack) begin
               if (!m_drop) begin
                  q_pc.push_back(m_reqpc); q_data.push_back(rdata);
                  m_fetch = m_fetch + 32'd4;
               end
               m_out = 1'b0; m_drop = 1'b0;
            end
         end else if (sz < DEPTH) begin
            m_out = 1'b1; m_reqpc = m_fetch; m_drop = 1'b0;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic        found;
      logic [31:0] got[3];
      int          n;

      vt[0]  = '{1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h000, 1'b0, 32'h000, 32'h0};
      vt[1]  = '{1'b0, 32'h0,   1'b1, 32'hA000_0000, 1'b1, 1'b1, 32'h000, 1'b0, 32'h000, 32'h0};
      vt[2]  = '{1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h004, 1'b1, 32'h000, 32'hA000_0000};
      vt[3]  = '{1'b0, 32'h0,   1'b1, 32'hA000_0004, 1'b1, 1'b1, 32'h004, 1'b0, 32'h000, 32'h0};
      vt[4]  = '{1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h008, 1'b1, 32'h004, 32'hA000_0004};
      vt[5]  = '{1'b0, 32'h0,   1'b1, 32'hA000_0008, 1'b1, 1'b1, 32'h008, 1'b0, 32'h000, 32'h0};
      vt[6]  = '{1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 1'b1, 32'h00C, 1'b1, 32'h008, 32'hA000_0008};
      vt[7]  = '{1'b1, 32'h200, 1'b1, 32'hA000_000C, 1'b1, 1'b1, 32'h00C, 1'b1, 32'h008, 32'hA000_0008};
      vt[8]  = '{1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h200, 1'b0, 32'h000, 32'h0};
      vt[9]  = '{1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h200, 1'b0, 32'h000, 32'h0};
      vt[10] = '{1'b0, 32'h0,   1'b1, 32'hB000_0200, 1'b1, 1'b1, 32'h200, 1'b0, 32'h000, 32'h0};
      vt[11] = '{1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 1'b1, 32'h204, 1'b1, 32'h200, 32'hB000_0200};

      mem_lat = 0;
      do_reset();

      // zero-wait cadence, then redirect coincident with ack and pop
      for (int i = 0; i < 12; i++) begin
         bus.redirect_valid = vt[i].rv; bus.redirect_pc = vt[i].rpc;
         bus.imem_ack = vt[i].ack; bus.imem_rdata = vt[i].rdata; bus.inst_ready = vt[i].rdy;
         #1;
         chk1("vec_imem_req", bus.imem_req, vt[i].e_req);
         if (vt[i].e_req) chk32("vec_imem_addr", bus.imem_addr, vt[i].e_addr);
         chk1("vec_inst_valid", bus.inst_valid, vt[i].e_valid);
         if (vt[i].e_valid) begin
            chk32("vec_inst_pc", bus.inst_pc, vt[i].e_pc);
            chk32("vec_inst_data", bus.inst_data, vt[i].e_data);
         end
         @(posedge clk); #1;
      end

      // fill to DEPTH with the core stalled, then resume
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0);
      chk1("full_no_req", obs_req, 1'b0);
      chk1("full_valid", obs_valid, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0);
      chk1("resume_req", obs_req, 1'b1);
      chk32("resume_addr", obs_addr, 32'h10);

      // redirect while a slow request is outstanding: drain stale word
      do_reset();
      mem_lat = 3;
      cycle(1'b0, 32'h0, 1'b1);
      mem_lat = 0;
      cycle(1'b1, 32'h103, 1'b1);
      chk1("drain_req_held", obs_req, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(1'b0, 32'h0, 1'b1);
         if (obs_valid) found = 1'b1;
      end
      chk1("drain_refetch_seen", found, 1'b1);
      chk32("drain_first_pc", obs_pc, 32'h100);

      // redirect near the top of the address space wraps modulo 2^32
      cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
      n = 0;
      for (int i = 0; i < 40 && n < 3; i++) begin
         cycle(1'b0, 32'h0, 1'b1);
         if (obs_valid) begin got[n] = obs_pc; n++; end
      end
      chk1("wrap_count", n == 3, 1'b1);
      chk32("wrap_pc0", got[0], 32'hFFFF_FFF8);
      chk32("wrap_pc1", got[1], 32'hFFFF_FFFC);
      chk32("wrap_pc2", got[2], 32'h0000_0000);

      // reset during REQ with two queued entries; late ack is ignored
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);
      mem_lat = 3;
      cycle(1'b0, 32'h0, 1'b0);
      chk1("pre_rst_valid", bus.inst_valid, 1'b1);
      chk1("pre_rst_req", bus.imem_req, 1'b1);
      do_reset();
      mem_lat = 0;
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0; bus.inst_ready = 1'b1;
      #1;
      chk1 ("post_rst_req", bus.imem_req, 1'b1);
      chk32("post_rst_addr", bus.imem_addr, RESET_PC);
      chk1 ("post_rst_valid", bus.inst_valid, 1'b0);
      @(posedge clk); #1;
      bus.imem_ack = 1'b0;
      #1;
      chk1 ("late_ack_nopush", bus.inst_valid, 1'b0);
      chk1 ("late_ack_req", bus.imem_req, 1'b1);
      chk32("late_ack_addr", bus.imem_addr, RESET_PC);
      m_out = 1'b1; m_reqpc = RESET_PC; m_drop = 1'b0;
      mem_busy = 1'b1; mem_wait = 0; mem_addr = RESET_PC;

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         logic        rv, rdy;
         logic [31:0] rpc;
         mem_lat = int'($urandom_range(0, 3));
         rv  = ($urandom_range(0, 15) == 0);
         rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         rdy = ($urandom_range(0, 9) < 7);
         cycle(rv, rpc, rdy);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-006 redirect_pc  input  32  new fetch address; bits [1:0] SHALL be ignored (treated as 0).
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  word-aligned read address.
REQ-009 imem_ack  input  1  memory returns imem_rdata this cycle; 1 cycle pulse.
REQ-010 imem_rdata  input  32  instruction word, valid only when imem_ack=1.
REQ-011 inst_valid  output  1  head entry available to the core.
REQ-012 inst_ready  input  1  core consumes head entry when inst_valid=1.
REQ-013 inst_data  output  32  head instruction word.
REQ-014 inst_pc  output  32  address of the head instruction.

Function
REQ-015 FSM states: IDLE, REQ, DRAIN; block SHALL hold at most one memory request outstanding.
REQ-016 IDLE: if (count + 0) < DEPTH, SHALL assert imem_req with imem_addr=fetch_pc and enter REQ next cycle; else stay IDLE, imem_req=0.
REQ-017 REQ: imem_req=1 and imem_addr SHALL stay stable until imem_ack; request SHALL never be withdrawn.
REQ-018 REQ with imem_ack and no redirect: push {fetch_pc, imem_rdata}, fetch_pc += 4, go IDLE.
REQ-019 fetch_pc arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-020 Queue SHALL be show-ahead: inst_valid = (count != 0); inst_data/inst_pc reflect head combinationally from registers.
REQ-021 Pop when inst_valid & inst_ready; simultaneous push and pop SHALL keep count unchanged; push never occurs when full (guaranteed by REQ-016).
REQ-022 Earliest inst_valid: cycle after imem_ack; back-to-back fetch with zero-wait memory SHALL sustain one instruction per 2 cycles (IDLE/REQ alternation).
REQ-023 redirect_valid SHALL, same edge: empty queue (count=0, pointers reset), fetch_pc <= {redirect_pc[31:2],2'b00}; a coincident pop or push SHALL be discarded.
REQ-024 Redirect in REQ without imem_ack: enter DRAIN; imem_req stays high with the stale address until imem_ack; response discarded; then IDLE.
REQ-025 Redirect in REQ with coincident imem_ack: data discarded, go IDLE (no DRAIN).
REQ-026 Redirect in DRAIN: update fetch_pc, remain DRAIN; with coincident imem_ack go IDLE.
REQ-027 Redirect in IDLE: go IDLE; next request SHALL use the new fetch_pc.
REQ-028 imem_ack in IDLE SHALL be ignored (no push, no state change).
REQ-029 inst_data/inst_pc are don't-care while inst_valid=0.

Reset
REQ-030 reset=1 SHALL immediately force: state IDLE, count 0, pointers 0, fetch_pc RESET_PC, imem_req 0, inst_valid 0, imem_addr RESET_PC; inst_data/inst_pc 0.
REQ-031 Reset asserted mid-request SHALL abandon it; a late imem_ack after reset release SHALL be ignored per REQ-028 only if state is IDLE; memory SHALL be reset concurrently by the system.
REQ-032 First imem_req SHALL assert in the first cycle after reset deasserts.

Verification
REQ-033 Reset release, zero-wait ack, inst_ready=1 -> inst_pc sequence 0x0,0x4,0x8 with rdata matched, one valid every 2 cycles.
REQ-034 inst_ready=0, DEPTH=4 -> exactly 4 pushes then imem_req=0; count=4; raise inst_ready -> fetching resumes at 0x10.
REQ-035 Redirect to 0x103 while REQ outstanding, ack 3 cycles later -> stale word dropped, DRAIN then request 0x100; first inst_pc=0x100.
REQ-036 Redirect coincident with imem_ack and inst_ready pop -> queue empty next cycle, no DRAIN, next imem_addr=redirect target.
REQ-037 Redirect to 0xFFFF_FFF8 -> inst_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-038 Assert reset during REQ with 2 queued entries -> outputs reset same cycle; post-release imem_addr=RESET_PC, inst_valid=0.
